// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: NPCOp encodings and reset fetch address.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    localparam logic [2:0] NPC_PC4 = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b011;

    // Encodings 1xx fall back to sequential flow and never redirect.
    function automatic logic is_redirect(input logic [2:0] op);
        return (op == NPC_BR) || (op == NPC_J) || (op == NPC_JR);
    endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational control-transfer target for the instruction held in PC.
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  npcop,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] target
);

    logic [31:0] pc4;

    assign pc4 = pc + 32'd4;

    always_comb begin
        target = pc4;
        case (npcop)
            NPC_BR:  target = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
            NPC_J:   target = {pc4[31:28], imm26, 2'b00};
            NPC_JR:  target = rs_data;
            default: target = pc4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with branch delay slot and likely-branch annulment.
// Optional FETCH_ALIGN_CHK_EN: misaligned fetch address raises adel and halts.
//
// state | meaning
// REQ   | issue fetch of fetch_pc (imem_req high for one cycle)
// WAIT  | waiting for imem_rvalid
// HOLD  | Instr/PC presented to decode until consumed
// HALT  | misaligned fetch detected; left only by reset
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  NPCOp,
    input  logic        Clrslot,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PC8,
    output logic        instr_valid,
    output logic        adel
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] redirect_pc;
    logic        redirect_pending;
    logic [31:0] target;
    logic [31:0] raw_next;
    logic [31:0] next_fetch;
    logic        misalign;
    logic        consume;

    npc_calc u_npc_calc (
        .pc      (PC),
        .npcop   (NPCOp),
        .imm16   (imm16),
        .imm26   (imm26),
        .rs_data (rs_data),
        .target  (target)
    );

    assign PC8     = PC + 32'd8;
    assign consume = (state == HOLD) && instr_valid && !stall;

    always_comb begin
        raw_next = PC + 32'd4;
        if (redirect_pending)
            raw_next = redirect_pc;
        else if (!is_redirect(NPCOp) && Clrslot)
            raw_next = PC8;
    end

`ifdef FETCH_ALIGN_CHK_EN
    assign misalign   = (raw_next[1:0] != 2'b00);
    assign next_fetch = raw_next;
`else
    assign misalign   = 1'b0;
    assign next_fetch = raw_next & ~32'h3;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= REQ;
            fetch_pc         <= RESET_PC;
            redirect_pc      <= RESET_PC;
            redirect_pending <= 1'b0;
            imem_req         <= 1'b0;
            imem_addr        <= RESET_PC;
            Instr            <= 32'd0;
            PC               <= RESET_PC;
            instr_valid      <= 1'b0;
            adel             <= 1'b0;
        end else begin
            case (state)
                // Entered with imem_req already set after a consume; out of
                // reset the request has to be raised here first.
                REQ: begin
                    if (imem_req) begin
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end else begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        Instr       <= imem_rdata;
                        PC          <= fetch_pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        instr_valid <= 1'b0;
                        fetch_pc    <= next_fetch;
                        if (redirect_pending) begin
                            redirect_pending <= 1'b0;
                        end else if (is_redirect(NPCOp)) begin
                            redirect_pc      <= target;
                            redirect_pending <= 1'b1;
                        end
                        if (misalign) begin
                            adel  <= 1'b1;
                            state <= HALT;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= next_fetch;
                            state     <= REQ;
                        end
                    end
                end
                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule
